// File: rtl/poly_synth_voices_if.sv
// poly_synth_voices_if: note-event inputs and mixed-sample outputs of poly_synth_voices
//   clear, start_note, end_note, note[6:0], wave_sel[1:0]  : events and waveform select (master -> slave)
//   latch_output[OUT_W-1:0], sample_valid                  : mixed sample and its update pulse
//   voice_active[NUM_VOICES-1:0], dropped                  : voice status and discarded-note pulse
interface poly_synth_voices_if #(
    parameter int NUM_VOICES = 4,
    parameter int OUT_W = 12
);
    logic clear;
    logic start_note;
    logic end_note;
    logic [6:0] note;
    logic [1:0] wave_sel;
    logic [OUT_W-1:0] latch_output;
    logic sample_valid;
    logic [NUM_VOICES-1:0] voice_active;
    logic dropped;
    modport master (
        output clear, start_note, end_note, note, wave_sel,
        input latch_output, sample_valid, voice_active, dropped
    );
    modport slave (
        input clear, start_note, end_note, note, wave_sel,
        output latch_output, sample_valid, voice_active, dropped
    );
endinterface

// File: rtl/poly_synth_voices.sv
// poly_synth_voices: polyphonic phase-accumulator synth with voice allocation/stealing and per-tick mixing
//   MHz10 : system clock
//   rst   : synchronous active-high reset
//   bus   : poly_synth_voices_if slave (note events in; mixed sample, voice status, dropped pulse out)
module poly_synth_voices #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W = 24,
    parameter int SAMPLE_W = 10,
    parameter int OUT_W = SAMPLE_W + $clog2(NUM_VOICES),
    parameter int SAMPLE_DIV = 227
) (
    input logic MHz10,
    input logic rst,
    poly_synth_voices_if.slave bus
);
    localparam int RW = $clog2(NUM_VOICES);
    localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;

    // Increments for octave 10 (MIDI notes 120..131); lower octaves are right shifts of these.
    function automatic logic [11:0][PHASE_W-1:0] base_table();
        real f;
        for (int s = 0; s < 12; s++) begin
            f = 440.0 * 2.0 ** ((51.0 + s) / 12.0);
            base_table[s] = PHASE_W'($rtoi(f * 2.0 ** PHASE_W * SAMPLE_DIV / 1.0e7 + 0.5));
        end
    endfunction

    localparam logic [11:0][PHASE_W-1:0] BASE_INC = base_table();

    function automatic logic [PHASE_W-1:0] note_inc(input logic [6:0] n);
        return BASE_INC[4'(n % 7'd12)] >> (4'd10 - 4'(n / 7'd12));
    endfunction

    function automatic logic [SAMPLE_W-1:0] voice_sample(input logic [PHASE_W-1:0] ph, input logic [1:0] w);
        logic [SAMPLE_W-1:0] p, t;
        p = ph[PHASE_W-1 -: SAMPLE_W];
        t = {p[SAMPLE_W-2:0], 1'b0};
        return w == 2'd0 ? p : w == 2'd1 ? {SAMPLE_W{p[SAMPLE_W-1]}} : w == 2'd2 ? (p[SAMPLE_W-1] ? ~t : t) : '0;
    endfunction

    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [6:0] note_q [NUM_VOICES];
    logic [6:0] note_d [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [PHASE_W-1:0] phase_d [NUM_VOICES];
    logic [PHASE_W-1:0] inc [NUM_VOICES];
    logic [RW-1:0] rank_q [NUM_VOICES];
    logic [RW-1:0] rank_d [NUM_VOICES];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] latch_q, latch_d, mix;
    logic valid_q, valid_d, dropped_q, dropped_d;
    logic tick, hit_found, idle_found;
    logic [RW-1:0] hit_idx, idle_idx, old_idx, alloc;

    assign tick = cnt_q == CW'(SAMPLE_DIV - 1);

    // Descending scan so the lowest-index idle voice wins; the note match serves both note-on and note-off.
    always_comb begin
        mix = '0;
        hit_found = 1'b0;
        idle_found = 1'b0;
        hit_idx = '0;
        idle_idx = '0;
        old_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            inc[v] = note_inc(note_q[v]);
            if (active_q[v]) mix = mix + OUT_W'(voice_sample(phase_q[v], bus.wave_sel));
            if (active_q[v] && note_q[v] == bus.note) begin
                hit_found = 1'b1;
                hit_idx = RW'(v);
            end
            if (!active_q[v]) begin
                idle_found = 1'b1;
                idle_idx = RW'(v);
            end
            if (rank_q[v] == RW'(NUM_VOICES - 1)) old_idx = RW'(v);
        end
        alloc = hit_found ? hit_idx : idle_found ? idle_idx : old_idx;
    end

    // Tick advance is computed first; events then override the voice they touch, so a
    // (re)allocated or released voice lands at phase 0 rather than advancing.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        active_d = active_q;
        note_d = note_q;
        rank_d = rank_q;
        for (int v = 0; v < NUM_VOICES; v++) phase_d[v] = (tick && active_q[v]) ? phase_q[v] + inc[v] : phase_q[v];
        latch_d = tick ? mix : latch_q;
        valid_d = tick;
        dropped_d = 1'b0;
        if (bus.clear) begin
            active_d = '0;
            for (int v = 0; v < NUM_VOICES; v++) phase_d[v] = '0;
            latch_d = '0;
        end else if (bus.end_note) begin
            dropped_d = bus.start_note;
            if (hit_found) begin
                active_d[hit_idx] = 1'b0;
                phase_d[hit_idx] = '0;
            end
        end else if (bus.start_note) begin
            active_d[alloc] = 1'b1;
            note_d[alloc] = bus.note;
            phase_d[alloc] = '0;
            for (int v = 0; v < NUM_VOICES; v++)
                rank_d[v] = RW'(v) == alloc ? '0 : rank_q[v] < rank_q[alloc] ? rank_q[v] + 1'b1 : rank_q[v];
        end
    end

    always_ff @(posedge MHz10) begin
        if (rst) begin
            active_q <= '0;
            cnt_q <= '0;
            latch_q <= '0;
            valid_q <= 1'b0;
            dropped_q <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                phase_q[v] <= '0;
                rank_q[v] <= RW'(v);
            end
        end else begin
            active_q <= active_d;
            cnt_q <= cnt_d;
            latch_q <= latch_d;
            valid_q <= valid_d;
            dropped_q <= dropped_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= note_d[v];
                phase_q[v] <= phase_d[v];
                rank_q[v] <= rank_d[v];
            end
        end
    end

    assign bus.latch_output = latch_q;
    assign bus.sample_valid = valid_q;
    assign bus.voice_active = active_q;
    assign bus.dropped = dropped_q;
endmodule

// File: tb/tb_poly_synth_voices.sv
// tb_poly_synth_voices: directed table, corner sequences and random stimulus against a reference model
module tb_poly_synth_voices;
    localparam int NV = 4, PW = 24, SW = 10, OW = 12, DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poly_synth_voices_if #(.NUM_VOICES(NV), .OUT_W(OW)) bus();
    poly_synth_voices #(.NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW), .OUT_W(OW), .SAMPLE_DIV(DIV))
        dut (.MHz10(clk), .rst(rst), .bus(bus));

    int n_chk = 0, n_fail = 0;

    // Reference state: voices plus an allocation-recency list (front = newest, back = oldest).
    bit m_act [NV];
    int m_note [NV];
    logic [PW-1:0] m_ph [NV];
    int order [$];
    int m_cnt, m_latch;
    bit m_valid, m_drop;

    typedef struct {
        bit cl, st, en;
        logic [6:0] nt;
        logic [NV-1:0] ea;
        bit ed;
        int ev;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] ref_inc(input int n);
        real f;
        longint b;
        f = 440.0 * 2.0 ** ((120.0 + (n % 12) - 69.0) / 12.0);
        b = $rtoi(f * 2.0 ** PW / (1.0e7 / DIV) + 0.5);
        return PW'(b >> (10 - n / 12));
    endfunction

    function automatic int ref_samp(input logic [PW-1:0] ph, input logic [1:0] w);
        int p;
        p = int'(ph >> (PW - SW));
        case (w)
            2'd0: return p;
            2'd1: return p >= 512 ? 1023 : 0;
            2'd2: return p < 512 ? 2 * p : 1023 - (2 * p - 1024);
            default: return 0;
        endcase
    endfunction

    function automatic logic [NV-1:0] exp_act();
        logic [NV-1:0] e;
        for (int i = 0; i < NV; i++) e[i] = m_act[i];
        return e;
    endfunction

    task automatic model_update();
        int s, v;
        bit tk;
        if (rst) begin
            order.delete();
            for (int i = 0; i < NV; i++) begin
                m_act[i] = 0;
                m_note[i] = 0;
                m_ph[i] = '0;
                order.push_back(i);
            end
            m_cnt = 0;
            m_latch = 0;
            m_valid = 0;
            m_drop = 0;
            return;
        end
        tk = m_cnt == DIV - 1;
        m_cnt = tk ? 0 : m_cnt + 1;
        m_valid = tk;
        m_drop = 0;
        if (tk) begin
            s = 0;
            for (int i = 0; i < NV; i++) if (m_act[i]) s += ref_samp(m_ph[i], bus.wave_sel);
            m_latch = s;
            for (int i = 0; i < NV; i++) if (m_act[i]) m_ph[i] = m_ph[i] + ref_inc(m_note[i]);
        end
        if (bus.clear) begin
            for (int i = 0; i < NV; i++) begin
                m_act[i] = 0;
                m_ph[i] = '0;
            end
            m_latch = 0;
        end else if (bus.end_note) begin
            m_drop = bus.start_note;
            for (int i = 0; i < NV; i++)
                if (m_act[i] && m_note[i] == int'(bus.note)) begin
                    m_act[i] = 0;
                    m_ph[i] = '0;
                end
        end else if (bus.start_note) begin
            v = -1;
            for (int i = 0; i < NV; i++) if (v < 0 && m_act[i] && m_note[i] == int'(bus.note)) v = i;
            for (int i = 0; i < NV; i++) if (v < 0 && !m_act[i]) v = i;
            if (v < 0) v = order[$];
            m_act[v] = 1;
            m_note[v] = int'(bus.note);
            m_ph[v] = '0;
            for (int k = 0; k < order.size(); k++)
                if (order[k] == v) begin
                    order.delete(k);
                    break;
                end
            order.push_front(v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("latch_output", bus.latch_output, m_latch);
        check("sample_valid", bus.sample_valid, m_valid);
        check("voice_active", bus.voice_active, exp_act());
        check("dropped", bus.dropped, m_drop);
    endtask

    task automatic drive(input bit cl, input bit st, input bit en, input logic [6:0] nt);
        bus.clear = cl;
        bus.start_note = st;
        bus.end_note = en;
        bus.note = nt;
    endtask

    task automatic note_on(input logic [6:0] nt);
        drive(0, 1, 0, nt);
        step();
        drive(0, 0, 0, nt);
    endtask

    task automatic note_off(input logic [6:0] nt);
        drive(0, 0, 1, nt);
        step();
        drive(0, 0, 0, nt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, sq;
        bus.wave_sel = 2'd0;
        drive(0, 0, 0, 7'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        tbl[0]  = '{0, 1, 0, 7'h30, 4'b0001, 0, 0};
        tbl[1]  = '{0, 1, 0, 7'h31, 4'b0011, 0, 1};
        tbl[2]  = '{0, 1, 0, 7'h32, 4'b0111, 0, 2};
        tbl[3]  = '{0, 1, 0, 7'h33, 4'b1111, 0, 3};
        tbl[4]  = '{0, 1, 0, 7'h34, 4'b1111, 0, 0};
        tbl[5]  = '{0, 1, 0, 7'h35, 4'b1111, 0, 1};
        tbl[6]  = '{0, 1, 0, 7'h35, 4'b1111, 0, 1};
        tbl[7]  = '{0, 0, 1, 7'h34, 4'b1110, 0, -1};
        tbl[8]  = '{0, 1, 1, 7'h30, 4'b1110, 1, -1};
        tbl[9]  = '{0, 1, 0, 7'h36, 4'b1111, 0, 0};
        tbl[10] = '{0, 0, 1, 7'h7F, 4'b1111, 0, -1};
        tbl[11] = '{0, 1, 1, 7'h36, 4'b1110, 1, -1};
        tbl[12] = '{0, 0, 1, 7'h35, 4'b1100, 0, -1};
        tbl[13] = '{0, 0, 1, 7'h32, 4'b1000, 0, -1};
        tbl[14] = '{0, 0, 1, 7'h33, 4'b0000, 0, -1};
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].cl, tbl[i].st, tbl[i].en, tbl[i].nt);
            step();
            check($sformatf("tbl%0d_active", i), bus.voice_active, tbl[i].ea);
            check($sformatf("tbl%0d_dropped", i), bus.dropped, tbl[i].ed);
            if (tbl[i].ev >= 0) check($sformatf("tbl%0d_voice_note", i), dut.note_q[tbl[i].ev], tbl[i].nt);
        end
        drive(0, 0, 0, 7'd0);
        step();
        check("dropped_one_cycle", bus.dropped, 0);

        note_on(7'h40);
        note_on(7'h42);
        k = 0;
        for (int i = 0; i < 8 * DIV; i++) begin
            step();
            if (bus.sample_valid) k++;
        end
        check("mix_ticks", k, 8);
        check("mix_active", bus.voice_active, 4'b0011);
        check("inc_0x40", dut.inc[0], ref_inc(8'h40));
        check("inc_octave", dut.inc[0] >> 1, ref_inc(8'h34));

        note_off(7'h40);
        note_off(7'h42);
        check("release_active", bus.voice_active, 4'b0000);
        for (int i = 0; i < DIV; i++) step();
        check("release_output", bus.latch_output, 0);
        note_on(7'h41);
        for (int i = 0; i < 3; i++) step();
        note_on(7'h41);
        check("retrig_active", bus.voice_active, 4'b0001);
        check("retrig_phase", dut.phase_q[0], 0);

        note_on(7'h60);
        note_on(7'h61);
        for (int i = 0; i < 6; i++) step();
        check("pre_reset_active", bus.voice_active, 4'b0111);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_latch", bus.latch_output, 0);
            check("reset_active", bus.voice_active, 0);
            check("reset_valid", bus.sample_valid, 0);
        end
        rst = 1'b0;
        k = 0;
        do begin
            step();
            k++;
        end while (!bus.sample_valid && k < 20);
        check("reset_to_first_valid", k, DIV);

        for (int n = 0; n < 4; n++) note_on(7'(8'h70 + n));
        for (int i = 0; i < 20; i++) step();
        for (int i = 0; i < DIV && m_cnt != DIV - 1; i++) step();
        check("clear_on_tick_setup", m_cnt, DIV - 1);
        drive(1, 0, 0, 7'd0);
        step();
        drive(0, 0, 0, 7'd0);
        check("clear_active", bus.voice_active, 0);
        check("clear_latch", bus.latch_output, 0);

        bus.wave_sel = 2'd1;
        note_on(7'h7C);
        sq = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (bus.sample_valid) begin
                sq++;
                check("square_levels", bus.latch_output == 0 || bus.latch_output == 1023, 1);
            end
        end
        check("square_ticks_seen", sq > 100, 1);

        bus.wave_sel = 2'd3;
        note_on(7'h7D);
        for (int i = 0; i < 2 * DIV; i++) step();
        check("silence_latch", bus.latch_output, 0);
        check("silence_active", bus.voice_active != 0, 1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) bus.wave_sel = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 25,
                  7'(96 + $urandom_range(0, 7)));
            rst = $urandom_range(0, 999) == 0;
            step();
        end
        rst = 1'b0;
        drive(0, 0, 0, 7'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
